pwm_capture: RTL

- Receive-side counterpart of the PWM generator: measures an incoming single-bit PWM waveform and recovers its period and high time in clock cycles.
- Used to loop back PMOD PWM outputs for self-test, and to decode externally generated PWM (e.g. servo or RC signals).
- One result is produced per PWM cycle, delimited by rising edges.
- Detects stuck-low and stuck-high inputs (0% / 100% duty) via a timeout.

---
 rtl/pwm_capture.sv | 66 ++++++
 1 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input, with stuck-level timeout
module pwm_capture #(
    parameter int COUNT_WIDTH = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_pwm,
    output logic [COUNT_WIDTH-1:0] o_period,
    output logic [COUNT_WIDTH-1:0] o_high,
    output logic                   o_valid,
    output logic                   o_timeout,
    output logic                   o_level
);
    typedef enum logic {IDLE, MEASURE} state_t;
    state_t state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic prev_q, prev_d;
    logic [COUNT_WIDTH-1:0] cnt_p_q, cnt_p_d, cnt_h_q, cnt_h_d;
    logic [COUNT_WIDTH-1:0] period_q, period_d, high_q, high_d;
    logic valid_q, valid_d, timeout_q, timeout_d;
    logic s_lvl, rise, sat, done;
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], i_pwm};
        s_lvl     = sync_q[SYNC_STAGES-1];
        prev_d    = s_lvl;
        rise      = s_lvl & ~prev_q;
        sat       = &cnt_p_q;
        done      = rise && state_q == MEASURE;
        cnt_p_d   = rise ? COUNT_WIDTH'(1) : cnt_p_q + COUNT_WIDTH'(!sat);
        cnt_h_d   = rise ? COUNT_WIDTH'(1) : cnt_h_q + COUNT_WIDTH'(s_lvl);
        period_d  = done ? cnt_p_q : period_q;
        high_d    = done ? cnt_h_q : high_q;
        valid_d   = done;
        timeout_d = done ? 1'b0 : timeout_q | (sat & ~rise);
        state_d   = rise ? MEASURE : (sat ? IDLE : state_q);
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            sync_q    <= '0;
            prev_q    <= 1'b0;
            cnt_p_q   <= '0;
            cnt_h_q   <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            cnt_p_q   <= cnt_p_d;
            cnt_h_q   <= cnt_h_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end
    assign o_period  = period_q;
    assign o_high    = high_q;
    assign o_valid   = valid_q;
    assign o_timeout = timeout_q;
    assign o_level   = s_lvl;
endmodule
